sram_req_bridge: RTL

- Converts a core/interconnect request channel (req/gnt, rvalid/rready) into the active-low pin protocol of the 8192x32 byte-enabled single-port SRAM wrapper.
- Sits directly upstream of that wrapper.
- Issues accesses combinationally on grant and captures read data one cycle later into a response FIFO.
- Flags out-of-range accesses with an error response instead of touching the SRAM.

---
 rtl/sram_req_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sram_req_bridge.sv
// Request/grant to active-low single-port SRAM bridge with an in-order response FIFO.
// Optional macro SRAM_REQ_BRIDGE_WR_RESP_EN: every granted write also returns a response.
module sram_req_bridge #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [31:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    sram_cen_o,
    output logic                    sram_gwen_o,
    output logic [DATA_WIDTH/8-1:0] sram_ben_o,
    output logic [ADDR_WIDTH-1:0]   sram_a_o,
    output logic [DATA_WIDTH-1:0]   sram_d_o,
    input  logic [DATA_WIDTH-1:0]   sram_q_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1) + 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_err_q, inflight_err_d;
    logic                  inflight_wr_q, inflight_wr_d;
    logic [DATA_WIDTH-1:0] mem_data_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [RESP_DEPTH];
    logic                  mem_err_q  [RESP_DEPTH];
    logic                  mem_err_d  [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] word_s;
    logic                  in_range_s, pop_s, gnt_s;
    logic [CNT_W-1:0]      occ_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic                  unused_addr_s;

    assign word_s        = addr_i[ADDR_WIDTH+1:2];
    assign in_range_s    = (addr_i[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
    assign unused_addr_s = ^addr_i[1:0];

    assign rvalid_o = (count_q != {CNT_W{1'b0}});
    assign rdata_o  = mem_data_q[rd_ptr_q];
    assign err_o    = mem_err_q[rd_ptr_q];
    assign pop_s    = rvalid_o & rready_i;
    // A slot freed by this cycle's pop may be reused by this cycle's grant.
    assign occ_s    = count_q + CNT_W'(inflight_q);
    assign gnt_s    = req_i & ~RST & ((occ_s - CNT_W'(pop_s)) < CNT_W'(RESP_DEPTH));
    assign gnt_o    = gnt_s;

    // SRAM pin drive in the grant cycle; address and data hold while idle.
    always_comb begin
        sram_cen_o  = 1'b1;
        sram_gwen_o = 1'b1;
        sram_ben_o  = {BE_W{1'b1}};
        a_d         = a_q;
        d_d         = d_q;
        if (gnt_s && in_range_s) begin
            if (!we_i) begin
                sram_cen_o = 1'b0;
                a_d        = word_s;
            end else if (be_i != {BE_W{1'b0}}) begin
                sram_cen_o  = 1'b0;
                sram_gwen_o = 1'b0;
                sram_ben_o  = ~be_i;
                a_d         = word_s;
                d_d         = wdata_i;
            end else begin
                a_d = a_q;
            end
        end else begin
            a_d = a_q;
        end
        sram_a_o = a_d;
        sram_d_o = d_d;
    end

    // Inflight tracking and response FIFO next state.
    always_comb begin
`ifdef SRAM_REQ_BRIDGE_WR_RESP_EN
        inflight_d = gnt_s;
`else
        inflight_d = gnt_s & ~we_i;
`endif
        inflight_err_d = ~in_range_s;
        inflight_wr_d  = we_i;
        push_data_s    = (inflight_err_q || inflight_wr_q) ? {DATA_WIDTH{1'b0}} : sram_q_i;
        mem_data_d     = mem_data_q;
        mem_err_d      = mem_err_q;
        if (inflight_q) begin
            mem_data_d[wr_ptr_q] = push_data_s;
            mem_err_d[wr_ptr_q]  = inflight_err_q;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(inflight_q) - CNT_W'(pop_s);
    end

    // State registers; reset drops every buffered and inflight response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q            <= {ADDR_WIDTH{1'b0}};
            d_q            <= {DATA_WIDTH{1'b0}};
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            inflight_wr_q  <= 1'b0;
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_data_q[i] <= {DATA_WIDTH{1'b0}};
                mem_err_q[i]  <= 1'b0;
            end
        end else begin
            a_q            <= a_d;
            d_q            <= d_d;
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
            inflight_wr_q  <= inflight_wr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mem_data_q     <= mem_data_d;
            mem_err_q      <= mem_err_d;
        end
    end

endmodule
